mac_arbiter: RTL and testbench

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mac_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_arbiter.sv
// Two-requester round-robin front end for a shared multiply-add datapath.
// Serialises the granted triplet as a, b, c and returns the result or a timeout error.
module mac_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] c0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] c1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          dp_validi,
  output logic [DW-1:0] dp_data_in,
  input  logic          dp_valido,
  input  logic [DW-1:0] dp_data_out,
  output logic          res_valid,
  output logic          res_id,
  output logic [DW-1:0] res_data,
  output logic          res_err,
  output logic          busy
);

  // Handshakes: a requester holds reqN and its triplet stable until gntN pulses for one
  // cycle in IDLE (capture edge). dp_validi has no backpressure; each high cycle delivers
  // one word. dp_valido is honoured only in WAIT. res_valid is a one-cycle strobe.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_SEND_C,
    S_WAIT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] c_q, c_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  logic          res_id_q, res_id_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic          gid;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    gid         = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    dp_validi   = 1'b0;
    dp_data_in  = '0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last wins.
          gid     = (req0 && req1) ? ~last_q : req1;
          gnt0    = ~rst & ~gid;
          gnt1    = ~rst & gid;
          id_d    = gid;
          last_d  = gid;
          a_d     = gid ? a1 : a0;
          b_d     = gid ? b1 : b0;
          c_d     = gid ? c1 : c0;
          state_d = S_SEND_A;
        end
      end
      S_SEND_A: begin
        dp_validi  = 1'b1;
        dp_data_in = a_q;
        state_d    = S_SEND_B;
      end
      S_SEND_B: begin
        dp_validi  = 1'b1;
        dp_data_in = b_q;
        state_d    = S_SEND_C;
      end
      S_SEND_C: begin
        dp_validi  = 1'b1;
        dp_data_in = c_q;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (dp_valido) begin
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_data_d  = dp_data_out;
          res_err_d   = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_data_d  = '0;
          res_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: transaction-level reference model (grant/result timing and
// values from the protocol rules) plus a behavioural a*b+c datapath.
module tb_mac_arbiter;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic          clk;
  logic          rst, req0, req1, gnt0, gnt1;
  logic [DW-1:0] a0, b0, c0, a1, b1, c1;
  logic          dp_validi, dp_valido, res_valid, res_id, res_err, busy;
  logic [DW-1:0] dp_data_in, dp_data_out, res_data;

  mac_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .c0(c0), .a1(a1), .b1(b1), .c1(c1),
    .gnt0(gnt0), .gnt1(gnt1), .dp_validi(dp_validi), .dp_data_in(dp_data_in),
    .dp_valido(dp_valido), .dp_data_out(dp_data_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err, cyc;

  // staged inputs, applied just after the next rising edge
  logic          n_rst, n_req0, n_req1;
  logic [DW-1:0] n_a0, n_b0, n_c0, n_a1, n_b1, n_c1;

  // reference model
  bit            m_free, m_last;
  int            m_t, m_res_cyc;
  logic [DW-1:0] m_ops[3];
  logic [DW+1:0] exp_q[$];

  // behavioural datapath
  bit            dp_respond, dp_pend;
  logic [DW-1:0] dp_val;
  logic [DW-1:0] dp_words[$];

  int            run_len, max_run, last_res_cyc;
  logic [DW-1:0] last_res_data;
  logic          last_res_err;
  int            res_ids[$];
  int            gnt_cycs[$];

  task automatic rand_ops();
    n_a0 = $urandom; n_b0 = $urandom; n_c0 = $urandom;
    n_a1 = $urandom; n_b1 = $urandom; n_c1 = $urandom;
  endtask

  function automatic bit spur_ok();
    return m_free || ((cyc + 1 - m_t) <= 3) || ((cyc + 1) >= m_res_cyc);
  endfunction

  task automatic tick(input bit spur);
    logic [DW+1:0] e;
    logic [DW-1:0] r, exp_din;
    bit            exp_rv, exp_busy, gid, exp_g0, exp_g1, exp_dv;
    int            k;
    @(posedge clk);
    #1;
    rst = n_rst; req0 = n_req0; req1 = n_req1;
    a0 = n_a0; b0 = n_b0; c0 = n_c0; a1 = n_a1; b1 = n_b1; c1 = n_c1;
    dp_valido   = dp_pend | spur;
    dp_data_out = dp_pend ? dp_val : DW'($urandom);
    dp_pend     = 1'b0;
    @(negedge clk);
    cyc++;
    if (rst) begin
      n_cmp++;
      if ({gnt0, gnt1, dp_validi, res_valid, res_id, res_err, busy} !== 7'b0 ||
          dp_data_in !== '0 || res_data !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got gnt=%b%b dv=%b din=%h rv=%b id=%b rd=%h err=%b busy=%b required all 0",
                 cyc, gnt0, gnt1, dp_validi, dp_data_in, res_valid, res_id, res_data, res_err, busy);
      end
      m_free = 1'b1; m_last = 1'b1; exp_q.delete();
      dp_words.delete(); dp_pend = 1'b0; run_len = 0;
    end else begin
      exp_rv = !m_free && (cyc == m_res_cyc);
      n_cmp++;
      if (res_valid !== exp_rv) begin
        n_err++;
        $display("FAIL res_valid cyc=%0d got %b required %b", cyc, res_valid, exp_rv);
      end
      if (res_valid === 1'b1) begin
        last_res_cyc = cyc; last_res_data = res_data; last_res_err = res_err;
        res_ids.push_back(int'(res_id));
      end
      if (exp_rv) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({res_err, res_id, res_data} !== e) begin
          n_err++;
          $display("FAIL res_fields cyc=%0d got err=%b id=%b data=%h required err=%b id=%b data=%h",
                   cyc, res_err, res_id, res_data, e[DW+1], e[DW], e[DW-1:0]);
        end
        m_free = 1'b1;
      end
      exp_busy = !m_free;
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, exp_busy);
      end
      exp_g0 = 1'b0; exp_g1 = 1'b0; gid = 1'b0;
      if (m_free && (req0 || req1)) begin
        gid = (req0 && req1) ? !m_last : req1;
        exp_g0 = !gid; exp_g1 = gid;
      end
      n_cmp++;
      if ({gnt0, gnt1} !== {exp_g0, exp_g1}) begin
        n_err++;
        $display("FAIL grant cyc=%0d got gnt0=%b gnt1=%b required gnt0=%b gnt1=%b",
                 cyc, gnt0, gnt1, exp_g0, exp_g1);
      end
      if (exp_g0 || exp_g1) begin
        m_free = 1'b0; m_last = gid; m_t = cyc; gnt_cycs.push_back(cyc);
        if (gid) begin m_ops[0] = a1; m_ops[1] = b1; m_ops[2] = c1; end
        else     begin m_ops[0] = a0; m_ops[1] = b0; m_ops[2] = c0; end
        r = m_ops[0] * m_ops[1] + m_ops[2];
        m_res_cyc = dp_respond ? cyc + 5 : cyc + 4 + TIMEOUT;
        e = dp_respond ? {1'b0, gid, r} : {1'b1, gid, {DW{1'b0}}};
        exp_q.push_back(e);
      end
      k = cyc - m_t;
      exp_dv = !m_free && (k >= 1) && (k <= 3);
      exp_din = '0;
      if (exp_dv) exp_din = m_ops[k-1];
      n_cmp++;
      if (dp_validi !== exp_dv || dp_data_in !== exp_din) begin
        n_err++;
        $display("FAIL dp_in cyc=%0d got v=%b d=%h required v=%b d=%h",
                 cyc, dp_validi, dp_data_in, exp_dv, exp_din);
      end
      if (dp_validi === 1'b1) begin
        dp_words.push_back(dp_data_in);
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (dp_words.size() == 3) begin
          if (dp_respond) begin
            dp_pend = 1'b1;
            dp_val  = dp_words[0] * dp_words[1] + dp_words[2];
          end
          dp_words.delete();
        end
      end else begin
        run_len = 0;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1; n_req0 = 1'b1; n_req1 = 1'b1; rand_ops();
    repeat (3) begin
      tick(1'b0);
      n_cmp++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        n_err++;
        $display("FAIL gnt_in_reset got %b%b required 00", gnt0, gnt1);
      end
    end
    n_rst = 1'b0; n_req0 = 1'b0; n_req1 = 1'b0;
    repeat (2) tick(1'b0);
  endtask

  task automatic test_single();
    int g;
    n_req0 = 1'b1; n_req1 = 1'b0; n_a0 = 3; n_b0 = 4; n_c0 = 5;
    tick(1'b0);
    g = cyc;
    n_req0 = 1'b0;
    repeat (6) tick(1'b0);
    n_cmp++;
    if (last_res_cyc !== g + 5 || last_res_data !== 32'd17 || last_res_err !== 1'b0) begin
      n_err++;
      $display("FAIL single got cyc=%0d data=%0d err=%b required cyc=%0d data=17 err=0",
               last_res_cyc, last_res_data, last_res_err, g + 5);
    end
  endtask

  task automatic test_simultaneous();
    int i0, g0;
    i0 = res_ids.size(); g0 = gnt_cycs.size();
    n_req0 = 1'b1; n_req1 = 1'b1; rand_ops();
    repeat (12) tick(1'b0);
    n_req0 = 1'b0; n_req1 = 1'b0;
    repeat (6) tick(1'b0);
    n_cmp++;
    if (res_ids.size() < i0 + 2 || gnt_cycs.size() < g0 + 2) begin
      n_err++;
      $display("FAIL simul_count got %0d results required at least 2", res_ids.size() - i0);
    end else if (res_ids[i0] != 0 || res_ids[i0+1] != 1 || gnt_cycs[g0+1] != gnt_cycs[g0] + 5) begin
      n_err++;
      $display("FAIL simul_order got ids %0d,%0d gap %0d required ids 0,1 gap 5",
               res_ids[i0], res_ids[i0+1], gnt_cycs[g0+1] - gnt_cycs[g0]);
    end
  endtask

  task automatic test_back_to_back();
    int g0;
    bit bad;
    g0 = gnt_cycs.size(); max_run = 0; bad = 1'b0;
    n_req1 = 1'b1; n_req0 = 1'b0;
    repeat (21) begin rand_ops(); tick(1'b0); end
    n_req1 = 1'b0;
    repeat (6) tick(1'b0);
    for (int i = g0 + 1; i < gnt_cycs.size(); i++)
      if (gnt_cycs[i] != gnt_cycs[i-1] + 5) bad = 1'b1;
    n_cmp++;
    if (bad || gnt_cycs.size() < g0 + 4 || max_run !== 3) begin
      n_err++;
      $display("FAIL back_to_back got grants=%0d spacing_bad=%b max_validi_run=%0d required >=4, 0, 3",
               gnt_cycs.size() - g0, bad, max_run);
    end
  endtask

  task automatic test_timeout();
    int g;
    dp_respond = 1'b0;
    n_req0 = 1'b1; rand_ops();
    tick(1'b0);
    g = cyc;
    n_req0 = 1'b0;
    repeat (TIMEOUT + 6) tick(1'b0);
    n_cmp++;
    if (last_res_cyc !== g + 4 + TIMEOUT || last_res_err !== 1'b1 || last_res_data !== '0) begin
      n_err++;
      $display("FAIL timeout got cyc=%0d err=%b data=%h required cyc=%0d err=1 data=0",
               last_res_cyc, last_res_err, last_res_data, g + 4 + TIMEOUT);
    end
    dp_respond = 1'b1;
  endtask

  task automatic test_reset_mid();
    int i0;
    n_req0 = 1'b1; rand_ops();
    tick(1'b0);
    n_req0 = 1'b0;
    tick(1'b0);
    n_rst = 1'b1;
    tick(1'b0);
    n_cmp++;
    if (busy !== 1'b0 || dp_validi !== 1'b0 || dp_data_in !== '0) begin
      n_err++;
      $display("FAIL reset_mid got busy=%b dv=%b din=%h required 0 0 0", busy, dp_validi, dp_data_in);
    end
    i0 = res_ids.size();
    tick(1'b0);
    n_rst = 1'b0;
    repeat (12) tick(1'b0);
    n_cmp++;
    if (res_ids.size() !== i0) begin
      n_err++;
      $display("FAIL reset_discard got %0d results required 0", res_ids.size() - i0);
    end
    n_req0 = 1'b1; n_a0 = 7; n_b0 = 6; n_c0 = 2;
    tick(1'b0);
    n_req0 = 1'b0;
    repeat (6) tick(1'b0);
    n_cmp++;
    if (last_res_data !== 32'd44 || res_ids.size() !== i0 + 1) begin
      n_err++;
      $display("FAIL after_reset got data=%0d results=%0d required 44 1",
               last_res_data, res_ids.size() - i0);
    end
  endtask

  task automatic test_spurious();
    int i0;
    i0 = res_ids.size();
    n_req0 = 1'b0; n_req1 = 1'b0;
    repeat (5) tick(1'b1);
    tick(1'b0);
    n_cmp++;
    if (res_ids.size() !== i0) begin
      n_err++;
      $display("FAIL spurious got %0d results required 0", res_ids.size() - i0);
    end
  endtask

  task automatic test_random();
    bit spur;
    repeat (600) begin
      if (m_free) dp_respond = ($urandom_range(0, 3) != 0);
      n_req0 = 1'($urandom_range(0, 1));
      n_req1 = 1'($urandom_range(0, 1));
      rand_ops();
      spur = spur_ok() && ($urandom_range(0, 5) == 0);
      tick(spur);
    end
    n_req0 = 1'b0; n_req1 = 1'b0; dp_respond = 1'b1;
    repeat (TIMEOUT + 6) tick(1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    dp_valido = 1'b0; dp_data_out = '0;
    n_rst = 1'b1; n_req0 = 1'b0; n_req1 = 1'b0;
    n_a0 = '0; n_b0 = '0; n_c0 = '0; n_a1 = '0; n_b1 = '0; n_c1 = '0;
    m_free = 1'b1; m_last = 1'b1; m_t = -100; m_res_cyc = -1;
    dp_respond = 1'b1; dp_pend = 1'b0; dp_val = '0;
    run_len = 0; max_run = 0; last_res_cyc = -1; last_res_data = '0; last_res_err = 1'b0;

    test_reset();
    test_single();
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
